// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter onto a single-port RAM,
// with a memory-mapped LED output register and switch input above the RAM range.
module mem_arbiter #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] LEDR_ADDR = 16'h2000,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 16'h2001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_i_read,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic              o_i_wait,
  output logic              o_i_rdvalid,
  output logic [DATA_W-1:0] o_i_rddata,
  input  logic              i_d_read,
  input  logic              i_d_write,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wrdata,
  output logic              o_d_wait,
  output logic              o_d_rdvalid,
  output logic [DATA_W-1:0] o_d_rddata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  input  logic [DATA_W-1:0] i_mem_rddata,
  input  logic [7:0]        i_SW,
  output logic [7:0]        o_LEDR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_i_q, last_i_d;   // 1: instruction port granted most recently
  logic [7:0]          led_q, led_d;
  logic                resp_ram_q, resp_ram_d;
  logic [DATA_W-1:0]   resp_val_q, resp_val_d;
  logic                grant_i_s, grant_d_s, mem_wr_s, d_req_s;
  logic [DATA_W-1:0]   resp_data_s;

  assign d_req_s = i_d_read | i_d_write;

  // Arbitration, next-state and RAM request decode
  always_comb begin
    state_d    = state_q;
    last_i_d   = last_i_q;
    led_d      = led_q;
    resp_ram_d = resp_ram_q;
    resp_val_d = resp_val_q;
    grant_i_s  = 1'b0;
    grant_d_s  = 1'b0;
    mem_wr_s   = 1'b0;
    o_mem_addr = '0;
    case (state_q)
      IDLE: begin
        if (i_i_read && (!d_req_s || !last_i_q)) begin
          grant_i_s = 1'b1;
        end else if (d_req_s) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_i_s) begin
          last_i_d   = 1'b1;
          o_mem_addr = i_i_addr;
          resp_ram_d = (i_i_addr < LEDR_ADDR);
          resp_val_d = '0;
          state_d    = RESP_I;
        end else if (grant_d_s) begin
          last_i_d   = 1'b0;
          o_mem_addr = i_d_addr;
          if (i_d_read) begin
            state_d    = RESP_D;
            resp_ram_d = (i_d_addr < LEDR_ADDR);
            // Switches are captured now so the returned value reflects the grant cycle
            resp_val_d = (i_d_addr == SW_ADDR) ? {{(DATA_W-8){1'b0}}, i_SW} : '0;
          end else if (i_d_addr < LEDR_ADDR) begin
            mem_wr_s = 1'b1;
          end else if (i_d_addr == LEDR_ADDR) begin
            led_d = i_d_wrdata[7:0];
          end else begin
            mem_wr_s = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin flag, LED register and pending-response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_i_q   <= 1'b0;
      led_q      <= 8'h00;
      resp_ram_q <= 1'b0;
      resp_val_q <= '0;
    end else begin
      state_q    <= state_d;
      last_i_q   <= last_i_d;
      led_q      <= led_d;
      resp_ram_q <= resp_ram_d;
      resp_val_q <= resp_val_d;
    end
  end

  assign resp_data_s  = resp_ram_q ? i_mem_rddata : resp_val_q;
  assign o_i_wait     = i_i_read & ~grant_i_s;
  assign o_d_wait     = d_req_s & ~grant_d_s;
  assign o_i_rdvalid  = (state_q == RESP_I);
  assign o_d_rdvalid  = (state_q == RESP_D);
  assign o_i_rddata   = o_i_rdvalid ? resp_data_s : '0;
  assign o_d_rddata   = o_d_rdvalid ? resp_data_s : '0;
  assign o_mem_wr     = mem_wr_s & ~reset;
  assign o_mem_wrdata = i_d_wrdata;
  assign o_LEDR       = led_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_i_read, i_d_read, i_d_write;
  logic [15:0] i_i_addr, i_d_addr;
  logic [31:0] i_d_wrdata, i_mem_rddata;
  logic [7:0]  i_SW;
  logic        o_i_wait, o_i_rdvalid, o_d_wait, o_d_rdvalid, o_mem_wr;
  logic [31:0] o_i_rddata, o_d_rddata, o_mem_wrdata;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_LEDR;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  localparam logic [15:0] LEDR_A = 16'h2000;
  localparam logic [15:0] SW_A   = 16'h2001;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_i_read(i_i_read), .i_i_addr(i_i_addr), .o_i_wait(o_i_wait),
    .o_i_rdvalid(o_i_rdvalid), .o_i_rddata(o_i_rddata),
    .i_d_read(i_d_read), .i_d_write(i_d_write), .i_d_addr(i_d_addr),
    .i_d_wrdata(i_d_wrdata), .o_d_wait(o_d_wait), .o_d_rdvalid(o_d_rdvalid),
    .o_d_rddata(o_d_rddata), .o_mem_addr(o_mem_addr), .o_mem_wr(o_mem_wr),
    .o_mem_wrdata(o_mem_wrdata), .i_mem_rddata(i_mem_rddata),
    .i_SW(i_SW), .o_LEDR(o_LEDR)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_f(input logic [15:0] a);
    if (a == 16'h0004) return 32'hDEADBEEF;
    return {a, a ^ 16'h5A5A};
  endfunction

  // RAM stand-in: one-cycle read latency with address-derived contents
  always @(posedge clk) i_mem_rddata <= ram_f(o_mem_addr);

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: pending response (0 none, 1 instr, 2 data), last winner, LEDs
  int          m_pend = 0;
  logic [31:0] m_val  = 32'h0;
  logic        m_last_i = 1'b0;
  logic [7:0]  m_led  = 8'h00;

  always @(negedge clk) begin
    logic gi, gd, dreq;
    dreq = i_d_read | i_d_write;
    gi = 1'b0;
    gd = 1'b0;
    if (m_pend == 0) begin
      if (i_i_read && dreq) begin
        gi = !m_last_i;
        gd = m_last_i;
      end else begin
        gi = i_i_read;
        gd = dreq;
      end
    end
    if (chk_en) begin
      chk1("i_wait", o_i_wait, i_i_read && !gi);
      chk1("d_wait", o_d_wait, dreq && !gd);
      chk1("i_rdvalid", o_i_rdvalid, m_pend == 1);
      chk1("d_rdvalid", o_d_rdvalid, m_pend == 2);
      chk32("i_rddata", o_i_rddata, (m_pend == 1) ? m_val : 32'h0);
      chk32("d_rddata", o_d_rddata, (m_pend == 2) ? m_val : 32'h0);
      chk1("mem_wr", o_mem_wr, gd && i_d_write && (i_d_addr < LEDR_A) && !reset);
      if (gd && i_d_write && (i_d_addr < LEDR_A)) chk32("mem_wrdata", o_mem_wrdata, i_d_wrdata);
      if (gi && (i_i_addr < LEDR_A)) chk32("mem_addr_i", {16'h0, o_mem_addr}, {16'h0, i_i_addr});
      if (gd && (i_d_addr < LEDR_A)) chk32("mem_addr_d", {16'h0, o_mem_addr}, {16'h0, i_d_addr});
      chk32("ledr", {24'h0, o_LEDR}, {24'h0, m_led});
    end
    if (reset) begin
      m_pend   <= 0;
      m_last_i <= 1'b0;
      m_led    <= 8'h00;
    end else if (m_pend != 0) begin
      m_pend <= 0;
    end else if (gi) begin
      m_last_i <= 1'b1;
      m_pend   <= 1;
      m_val    <= (i_i_addr < LEDR_A) ? ram_f(i_i_addr) : 32'h0;
    end else if (gd) begin
      m_last_i <= 1'b0;
      if (i_d_read) begin
        m_pend <= 2;
        if (i_d_addr < LEDR_A)      m_val <= ram_f(i_d_addr);
        else if (i_d_addr == SW_A)  m_val <= {24'h0, i_SW};
        else                        m_val <= 32'h0;
      end else if (i_d_addr == LEDR_A) begin
        m_led <= i_d_wrdata[7:0];
      end
    end
  end

  task automatic step(input logic rst, input logic ir, input logic [15:0] ia,
                      input logic dr, input logic dw, input logic [15:0] da,
                      input logic [31:0] dwd, input logic [7:0] sw);
    @(posedge clk);
    #1;
    reset = rst; i_i_read = ir; i_i_addr = ia;
    i_d_read = dr; i_d_write = dw; i_d_addr = da; i_d_wrdata = dwd; i_SW = sw;
    @(negedge clk);
  endtask

  task automatic idle(input logic rst, input logic [7:0] sw);
    step(rst, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, sw);
  endtask

  initial begin
    reset = 1'b1; i_i_read = 1'b0; i_i_addr = 16'h0; i_d_read = 1'b0; i_d_write = 1'b0;
    i_d_addr = 16'h0; i_d_wrdata = 32'h0; i_SW = 8'h00;
    idle(1'b1, 8'h00);
    idle(1'b1, 8'h00);
    chk_en = 1'b1;
    chk32("rst_ledr", {24'h0, o_LEDR}, 32'h0);
    chk1("rst_i_rdvalid", o_i_rdvalid, 1'b0);
    chk1("rst_d_rdvalid", o_d_rdvalid, 1'b0);
    chk1("rst_mem_wr", o_mem_wr, 1'b0);

    // Repeated conflict: grants alternate I, D, I, D starting with instruction
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 16'h0008, 1'b1, 1'b0, 16'h0020, 32'h0, 8'h00);
      chk1("rr_i_wait", o_i_wait, (k % 4) != 0);
      chk1("rr_d_wait", o_d_wait, (k % 4) != 2);
    end
    idle(1'b0, 8'h00);

    // Instruction-only RAM read
    step(1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    chk1("ird_wait", o_i_wait, 1'b0);
    idle(1'b0, 8'h00);
    chk1("ird_valid", o_i_rdvalid, 1'b1);
    chk32("ird_data", o_i_rddata, 32'hDEADBEEF);
    idle(1'b0, 8'h00);
    chk1("ird_done", o_i_rdvalid, 1'b0);

    // Data RAM write wins after an instruction grant; instruction follows
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0010, 32'h12345678, 8'h00);
    chk1("dwr_d_wait", o_d_wait, 1'b0);
    chk1("dwr_mem_wr", o_mem_wr, 1'b1);
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    chk1("dwr_i_next", o_i_wait, 1'b0);
    chk1("dwr_wr_once", o_mem_wr, 1'b0);
    idle(1'b0, 8'h00);

    // LED write
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2000, 32'h000000A5, 8'h00);
    chk1("led_no_memwr", o_mem_wr, 1'b0);
    idle(1'b0, 8'h00);
    chk32("led_val", {24'h0, o_LEDR}, 32'h000000A5);
    chk1("led_no_rdvalid", o_d_rdvalid, 1'b0);

    // Switch read samples in the grant cycle
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h2001, 32'h0, 8'hAA);
    idle(1'b0, 8'h55);
    chk1("sw_valid", o_d_rdvalid, 1'b1);
    chk32("sw_data", o_d_rddata, 32'h000000AA);

    // Unmapped high addresses
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h3000, 32'h0, 8'h55);
    idle(1'b0, 8'h55);
    chk32("hi_rd_zero", o_d_rddata, 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2005, 32'h000000FF, 8'h55);
    idle(1'b0, 8'h55);
    chk32("hi_wr_ignored", {24'h0, o_LEDR}, 32'h000000A5);
    step(1'b0, 1'b1, 16'h2000, 1'b0, 1'b0, 16'h0, 32'h0, 8'h55);
    idle(1'b0, 8'h55);
    chk1("i_hi_valid", o_i_rdvalid, 1'b1);
    chk32("i_hi_zero", o_i_rddata, 32'h0);

    // Reset during RESP_D discards the response
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 8'h00);
    idle(1'b1, 8'h00);
    idle(1'b0, 8'h00);
    chk1("rstd_no_valid", o_d_rdvalid, 1'b0);
    chk32("rstd_ledr", {24'h0, o_LEDR}, 32'h0);

    // Reset in a grant cycle: LED write and read both discarded
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2000, 32'h0000003C, 8'h00);
    idle(1'b0, 8'h00);
    chk32("rstg_ledr", {24'h0, o_LEDR}, 32'h0);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0050, 32'h0, 8'h00);
    idle(1'b0, 8'h00);
    chk1("rstg_no_valid", o_d_rdvalid, 1'b0);

    // After reset the first conflict goes to the instruction port
    step(1'b0, 1'b1, 16'h0060, 1'b1, 1'b0, 16'h0070, 32'h0, 8'h00);
    chk1("post_rst_i", o_i_wait, 1'b0);
    chk1("post_rst_d", o_d_wait, 1'b1);
    idle(1'b0, 8'h00);
    idle(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width of both requester ports and the RAM port.
REQ-002 Parameter DATA_W, default 32, data width of all data buses.
REQ-003 Parameter LEDR_ADDR, default 16'h2000, word address of the LED output register.
REQ-004 Parameter SW_ADDR, default 16'h2001, word address of the switch input.
REQ-005 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 i_i_read  input  1  instruction port read request.
REQ-009 i_i_addr  input  ADDR_W  instruction port word address.
REQ-010 o_i_wait  output  1  instruction request not accepted this cycle.
REQ-011 o_i_rdvalid  output  1  instruction read data valid.
REQ-012 o_i_rddata  output  DATA_W  instruction read data.
REQ-013 i_d_read, i_d_write  input  1 each  data port read/write requests; never both high.
REQ-014 i_d_addr  input  ADDR_W; i_d_wrdata  input  DATA_W  data port address and write data.
REQ-015 o_d_wait, o_d_rdvalid  output  1 each; o_d_rddata  output  DATA_W  data port handshake and read data.
REQ-016 o_mem_addr  output  ADDR_W; o_mem_wr  output  1; o_mem_wrdata  output  DATA_W  single-port RAM request, 1-cycle read latency.
REQ-017 i_mem_rddata  input  DATA_W  RAM read data, valid the cycle after the address.
REQ-018 i_SW  input  8  switch values; o_LEDR  output  8  LED register.

Function
REQ-019 States SHALL be IDLE, RESP_I, RESP_D; grants SHALL occur only in IDLE.
REQ-020 In IDLE with one request pending, that port SHALL be granted the same cycle; its wait output SHALL be 0 that cycle, else wait = request.
REQ-021 With both requests pending in IDLE, grant SHALL go to the port not granted most recently (round-robin); last-grant flag SHALL reset to "data", so instruction wins the first conflict.
REQ-022 Wait outputs SHALL be combinational from requests, state and last-grant flag.
REQ-023 Granted read: IDLE -> RESP_I or RESP_D; rdvalid of that port SHALL be 1 for exactly the next cycle, then IDLE. No grant SHALL occur in RESP_*.
REQ-024 Granted data write: single cycle, state stays IDLE, no rdvalid.
REQ-025 RAM range = addresses < LEDR_ADDR: o_mem_addr = granted address; o_mem_wr = 1 only for a granted RAM write.
REQ-026 Data write to LEDR_ADDR SHALL load i_d_wrdata[7:0] into o_LEDR on that edge; RAM SHALL not be written.
REQ-027 Data read of SW_ADDR SHALL return {zeros, i_SW} sampled in the grant cycle, delivered with the same 1-cycle latency.
REQ-028 Other addresses >= LEDR_ADDR: writes ignored, reads return 0 with normal latency; instruction reads at >= LEDR_ADDR return 0.
REQ-029 rddata outputs SHALL be 0 whenever the corresponding rdvalid is 0.
REQ-030 o_mem_wr SHALL be 0 in RESP_* and whenever nothing is granted.

Reset
REQ-031 Reset SHALL force IDLE, o_LEDR = 0, all rdvalid = 0, o_mem_wr = 0, last-grant = data.
REQ-032 Reset asserted in a grant cycle or RESP_* SHALL discard the transaction: no rdvalid the following cycle, no LEDR update.

Verification
REQ-033 Instruction-only read addr 16'h0004, RAM returns 32'hDEADBEEF -> o_i_wait 0 in grant cycle; o_i_rdvalid=1 with DEADBEEF next cycle; IDLE after.
REQ-034 Both ports read in same IDLE cycle after reset -> instruction granted first, o_d_wait=1 for 2 cycles; data granted on return to IDLE; repeated conflict alternates I, D, I, D.
REQ-035 Data write 32'h000000A5 to 16'h2000 -> o_LEDR=8'hA5 after edge; o_mem_wr stays 0; no rdvalid.
REQ-036 i_SW=8'hAA, data read 16'h2001 -> o_d_rdvalid=1, o_d_rddata=32'h000000AA next cycle.
REQ-037 Data write to 16'h0010 concurrent with instruction request, last grant = instruction -> data wins, o_mem_wr=1 one cycle, instruction granted next cycle.
REQ-038 Reset asserted in RESP_D -> o_d_rdvalid=0 next cycle, o_LEDR=0, next conflict grants instruction.
